// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: owns mtimecmp/msip, synchronises ext_irq,
// builds mip and sequences one non-nested trap request per handler.
module irq_ctrl #(
    parameter int XLEN        = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [63:0]     mtime,
    input  logic            cmp_we,
    input  logic            cmp_hi,
    input  logic [XLEN-1:0] cmp_wdata,
    input  logic            msip_we,
    input  logic            msip_wdata,
    input  logic            ext_irq,
    input  logic            mstatus_mie,
    input  logic [XLEN-1:0] mie,
    input  logic            retire,
    input  logic            irq_ack,
    input  logic            s_mret,
    output logic            irq_req,
    output logic [XLEN-1:0] irq_cause,
    output logic [XLEN-1:0] mip,
    output logic [63:0]     mtimecmp
);
    typedef enum logic [1:0] {IDLE, REQ, HANDLER} state_e;

    state_e                 state_q, state_d;
    logic [63:0]            cmp_q, cmp_d;
    logic                   msip_q, msip_d;
    logic                   mtip_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [XLEN-1:0]        cause_q, cause_d;
    logic                   meip, p_ext, p_sw, p_tmr, take;

    // On RV32 mtimecmp is written one half at a time; RV64 writes it whole.
    if (XLEN == 64) begin : g_cmp64
        logic unused_cmp_hi;
        assign unused_cmp_hi = cmp_hi;
        always_comb begin
            cmp_d = cmp_q;
            if (cmp_we) cmp_d = cmp_wdata;
        end
    end else begin : g_cmp32
        always_comb begin
            cmp_d = cmp_q;
            if (cmp_we) begin
                if (cmp_hi) cmp_d[63:32] = cmp_wdata[31:0];
                else        cmp_d[31:0]  = cmp_wdata[31:0];
            end
        end
    end

    assign msip_d = msip_we ? msip_wdata : msip_q;

    // mtip samples the pre-write mtimecmp, so a same-cycle write lands a cycle later.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cmp_q  <= '1;
            msip_q <= 1'b0;
            mtip_q <= 1'b0;
            sync_q <= '0;
        end else begin
            cmp_q  <= cmp_d;
            msip_q <= msip_d;
            mtip_q <= (mtime >= cmp_q);
            sync_q <= {sync_q[SYNC_STAGES-2:0], ext_irq};
        end
    end

    assign meip = sync_q[SYNC_STAGES-1];

    always_comb begin
        mip     = '0;
        mip[11] = meip;
        mip[7]  = mtip_q;
        mip[3]  = msip_q;
    end

    logic unused_mie;
    assign unused_mie = ^{mie[XLEN-1:12], mie[10:8], mie[6:4], mie[2:0]};

    assign p_ext = meip & mie[11];
    assign p_sw  = msip_q & mie[3];
    assign p_tmr = mtip_q & mie[7];
    assign take  = retire & mstatus_mie & (p_ext | p_sw | p_tmr);

    // Cause is captured once on entry and held through REQ regardless of the source.
    always_comb begin
        cause_d = cause_q;
        if (state_q == IDLE && take) begin
            cause_d            = '0;
            cause_d[XLEN-1]    = 1'b1;
            if (p_ext)     cause_d[3:0] = 4'd11;
            else if (p_sw) cause_d[3:0] = 4'd3;
            else           cause_d[3:0] = 4'd7;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take)    state_d = REQ;
            REQ:     if (irq_ack) state_d = HANDLER;
            HANDLER: if (s_mret)  state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    always_comb begin
        irq_req   = (state_q == REQ);
        irq_cause = cause_q;
        mtimecmp  = cmp_q;
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus a randomized run checked
// against a cycle-level model of the interrupt rules.
module tb_irq_ctrl;
    localparam int XLEN = 32;
    localparam int SS   = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic [63:0]     mtime;
    logic            cmp_we, cmp_hi;
    logic [XLEN-1:0] cmp_wdata;
    logic            msip_we, msip_wdata, ext_irq, mstatus_mie;
    logic [XLEN-1:0] mie;
    logic            retire, irq_ack, s_mret;
    logic            irq_req;
    logic [XLEN-1:0] irq_cause, mip;
    logic [63:0]     mtimecmp;

    int total = 0;
    int bad   = 0;
    logic mt_run = 1'b0;

    irq_ctrl #(.XLEN(XLEN), .SYNC_STAGES(SS)) dut (
        .clock(clock), .reset(reset), .mtime(mtime),
        .cmp_we(cmp_we), .cmp_hi(cmp_hi), .cmp_wdata(cmp_wdata),
        .msip_we(msip_we), .msip_wdata(msip_wdata), .ext_irq(ext_irq),
        .mstatus_mie(mstatus_mie), .mie(mie), .retire(retire),
        .irq_ack(irq_ack), .s_mret(s_mret), .irq_req(irq_req),
        .irq_cause(irq_cause), .mip(mip), .mtimecmp(mtimecmp)
    );

    always #5 clock = ~clock;

    // Reference model: registers as the spec describes them, plus request/handler flags.
    logic [63:0]   m_cmp;
    logic          m_msip, m_mtip, m_req, m_hdl;
    logic [SS-1:0] m_sh;
    logic [31:0]   m_cause;
    logic          e_p, s_p, t_p;
    wire  [31:0]   m_mip = {20'b0, m_sh[SS-1], 3'b0, m_mtip, 3'b0, m_msip, 3'b0};

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_cmp = '1; m_msip = 0; m_mtip = 0; m_sh = '0;
            m_req = 0; m_hdl = 0; m_cause = '0;
        end else begin
            e_p = m_sh[SS-1] & mie[11];
            s_p = m_msip & mie[3];
            t_p = m_mtip & mie[7];
            if (m_req) begin
                if (irq_ack) begin m_req = 0; m_hdl = 1; end
            end else if (m_hdl) begin
                if (s_mret) m_hdl = 0;
            end else if (retire && mstatus_mie && (e_p || s_p || t_p)) begin
                m_req   = 1;
                m_cause = 32'h8000_0000 + (e_p ? 32'd11 : s_p ? 32'd3 : 32'd7);
            end
            m_mtip = (mtime >= m_cmp);
            if (cmp_we) begin
                if (cmp_hi) m_cmp[63:32] = cmp_wdata;
                else        m_cmp[31:0]  = cmp_wdata;
            end
            m_sh = {m_sh[SS-2:0], ext_irq};
            if (msip_we) m_msip = msip_wdata;
        end
    end

    task automatic tick();
        @(negedge clock);
        if (mt_run) mtime = mtime + 64'd1;
    endtask

    task automatic finish_irq();
        irq_ack = 1; tick(); irq_ack = 0;
        s_mret = 1;  tick(); s_mret = 0;
    endtask

    task automatic test_reset();
        reset = 0; mtime = 0; cmp_we = 0; cmp_hi = 0; cmp_wdata = 0;
        msip_we = 0; msip_wdata = 0; ext_irq = 0; mstatus_mie = 0; mie = 0;
        retire = 0; irq_ack = 0; s_mret = 0;
        tick(); tick(); reset = 1; tick();
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", irq_req); end
        total++; if (irq_cause !== 32'h0) begin bad++; $display("FAIL rst_cause: got %h want 0", irq_cause); end
        total++; if (mip !== 32'h0) begin bad++; $display("FAIL rst_mip: got %h want 0", mip); end
        total++; if (mtimecmp !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL rst_cmp: got %h want all ones", mtimecmp); end
        msip_we = 1; msip_wdata = 1; cmp_we = 1; cmp_wdata = 32'h55;
        tick(); msip_we = 0; cmp_we = 0; tick();
        total++; if (mip !== 32'h8) begin bad++; $display("FAIL msip_set: got %h want 8", mip); end
        #2 reset = 0;
        #1;
        total++; if (mip !== 32'h0) begin bad++; $display("FAIL async_mip: got %h want 0", mip); end
        total++; if (mtimecmp !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL async_cmp: got %h want all ones", mtimecmp); end
        tick(); reset = 1;
    endtask

    task automatic test_timer();
        int guard;
        mtime = 64'hF0;
        cmp_we = 1; cmp_hi = 1; cmp_wdata = 0; tick();
        cmp_hi = 0; cmp_wdata = 32'h100; tick();
        cmp_we = 0; mie = 32'h80; mstatus_mie = 1; tick();
        total++; if (mtimecmp !== 64'h100) begin bad++; $display("FAIL tmr_cmp: got %h want 100", mtimecmp); end
        mt_run = 1; guard = 0;
        while (mtime != 64'h100 && guard < 64) begin tick(); guard++; end
        total++; if (mip !== 32'h0) begin bad++; $display("FAIL tmr_before: got %h want 0", mip); end
        tick(); mt_run = 0;
        total++; if (mip !== 32'h80) begin bad++; $display("FAIL tmr_mip: got %h want 80", mip); end
        retire = 1; tick(); retire = 0;
        total++; if (irq_req !== 1'b1 || irq_cause !== 32'h8000_0007) begin
            bad++; $display("FAIL tmr_req: got %b/%h want 1/80000007", irq_req, irq_cause); end
        irq_ack = 1; tick(); irq_ack = 0;
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL tmr_ack: got %b want 0", irq_req); end
        s_mret = 1; retire = 1; tick(); s_mret = 0;
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL tmr_hdl_retire: got %b want 0", irq_req); end
        tick(); retire = 0;
        total++; if (irq_req !== 1'b1) begin bad++; $display("FAIL tmr_rereq: got %b want 1", irq_req); end
        finish_irq();
    endtask

    task automatic test_priority();
        msip_we = 1; msip_wdata = 1; ext_irq = 1; mie = 32'h888; tick();
        msip_we = 0;
        for (int k = 0; k < SS + 1; k++) tick();
        total++; if (mip !== 32'h888) begin bad++; $display("FAIL pri_mip: got %h want 888", mip); end
        retire = 1; tick(); retire = 0;
        total++; if (irq_cause !== 32'h8000_000B) begin bad++; $display("FAIL pri_ext: got %h want 8000000b", irq_cause); end
        ext_irq = 0; finish_irq();
        for (int k = 0; k < SS + 1; k++) tick();
        retire = 1; tick(); retire = 0;
        total++; if (irq_cause !== 32'h8000_0003) begin bad++; $display("FAIL pri_sw: got %h want 80000003", irq_cause); end
        finish_irq();
        msip_we = 1; msip_wdata = 0; tick(); msip_we = 0; tick();
        retire = 1; tick(); retire = 0;
        total++; if (irq_cause !== 32'h8000_0007) begin bad++; $display("FAIL pri_tmr: got %h want 80000007", irq_cause); end
        finish_irq();
    endtask

    task automatic test_masking();
        int seen;
        mie = 32'h80; mstatus_mie = 0; retire = 1; seen = 0;
        for (int k = 0; k < 20; k++) begin tick(); seen |= int'(irq_req); end
        mstatus_mie = 1; mie = 32'h008;
        for (int k = 0; k < 20; k++) begin tick(); seen |= int'(irq_req); end
        total++; if (seen !== 0) begin bad++; $display("FAIL mask_held: got %0d want 0", seen); end
        retire = 0; mie = 32'h80; tick();
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL mask_noretire: got %b want 0", irq_req); end
        retire = 1; tick(); retire = 0;
        total++; if (irq_req !== 1'b1) begin bad++; $display("FAIL mask_enable: got %b want 1", irq_req); end
        finish_irq();
    endtask

    task automatic test_sync();
        mie = 32'h800; ext_irq = 1;
        for (int k = 1; k <= SS; k++) begin
            tick();
            total++; if (mip[11] !== (k == SS)) begin bad++; $display("FAIL sync_edge%0d: got %b want %b", k, mip[11], k == SS); end
        end
        retire = 1; tick(); retire = 0; ext_irq = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++; if (irq_req !== 1'b1 || irq_cause !== 32'h8000_000B) begin
                bad++; $display("FAIL sync_hold: got %b/%h want 1/8000000b", irq_req, irq_cause); end
        end
        irq_ack = 1; tick(); irq_ack = 0;
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL sync_ack: got %b want 0", irq_req); end
        s_mret = 1; tick(); s_mret = 0;
    endtask

    task automatic test_reset_mid_req();
        int seen;
        mie = 32'h80; retire = 1; tick(); retire = 0;
        total++; if (irq_req !== 1'b1) begin bad++; $display("FAIL mid_req: got %b want 1", irq_req); end
        #2 reset = 0;
        #1;
        total++; if (irq_req !== 1'b0 || irq_cause !== 32'h0) begin
            bad++; $display("FAIL mid_rst: got %b/%h want 0/0", irq_req, irq_cause); end
        tick(); reset = 1;
        cmp_we = 1; cmp_hi = 0; cmp_wdata = 0; tick();
        cmp_hi = 1; tick(); cmp_we = 0; seen = 0;
        for (int k = 0; k < 4; k++) begin tick(); seen |= int'(irq_req); end
        total++; if (seen !== 0) begin bad++; $display("FAIL mid_norereq: got %0d want 0", seen); end
        retire = 1; tick(); retire = 0;
        total++; if (irq_req !== 1'b1 || irq_cause !== 32'h8000_0007) begin
            bad++; $display("FAIL mid_newreq: got %b/%h want 1/80000007", irq_req, irq_cause); end
        finish_irq();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        mtime = 64'h0000_0000_FFFF_FF00; mt_run = 1;
        for (int i = 0; i < 400; i++) begin
            retire      = ($urandom_range(0, 2) == 0);
            irq_ack     = ($urandom_range(0, 3) == 0);
            s_mret      = ($urandom_range(0, 3) == 0);
            mstatus_mie = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) mie = $urandom;
            if ($urandom_range(0, 9) == 0) ext_irq = ~ext_irq;
            msip_we     = ($urandom_range(0, 7) == 0);
            msip_wdata  = 1'($urandom);
            cmp_we      = ($urandom_range(0, 7) == 0);
            cmp_hi      = ($urandom_range(0, 3) == 0);
            cmp_wdata   = cmp_hi ? mtime[63:32] + 32'($urandom_range(0, 1))
                                 : mtime[31:0] + 32'($urandom_range(0, 16));
            tick();
            total++;
            if (irq_req !== m_req || irq_cause !== m_cause || mip !== m_mip || mtimecmp !== m_cmp) begin
                bad++; errs++;
                if (errs <= 5)
                    $display("FAIL rand_c%0d: got req=%b cause=%h mip=%h cmp=%h want req=%b cause=%h mip=%h cmp=%h",
                             i, irq_req, irq_cause, mip, mtimecmp, m_req, m_cause, m_mip, m_cmp);
            end
        end
        mt_run = 0; retire = 0; irq_ack = 0; s_mret = 0; msip_we = 0; cmp_we = 0;
    endtask

    initial begin
        test_reset();
        test_timer();
        test_priority();
        test_masking();
        test_sync();
        test_reset_mid_req();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
